// File: rtl/alu_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_sequencer_if: command, ALU and response bundles of the ALU     |
// | sequencer.                                        Revision: 1.0    |
// +--------------------------------------------------------------------+
interface alu_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;

   logic [1:0]       alu_op;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic             alu_in_valid;
   logic [WIDTH-1:0] alu_out;
   logic             alu_out_valid;
   logic             alu_n;
   logic             alu_z;
   logic             alu_c;
   logic             alu_v;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic [3:0]       rsp_flags;

   // Sequencer side.
   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b,
      output cmd_ready,
      output alu_op, alu_a, alu_b, alu_in_valid,
      input  alu_out, alu_out_valid, alu_n, alu_z, alu_c, alu_v,
      output rsp_valid, rsp_data, rsp_flags,
      input  rsp_ready
   );

   // Command source, ALU and response sink side.
   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b,
      input  cmd_ready,
      input  alu_op, alu_a, alu_b, alu_in_valid,
      output alu_out, alu_out_valid, alu_n, alu_z, alu_c, alu_v,
      input  rsp_valid, rsp_data, rsp_flags,
      output rsp_ready
   );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_sequencer: issues commands to a 2-stage ALU, pairs results     |
// | with flags and buffers responses in a credit-guarded FIFO.         |
// |                                                   Revision: 1.0    |
// +--------------------------------------------------------------------+
module alu_sequencer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  wire logic      clk,
   input  wire logic      reset,
   alu_sequencer_if.slave bus,
   output logic           busy,
   output logic           err
);
   localparam logic [1:0] c_OP_NOP = 2'd2;
   localparam int         c_PTR_W  = $clog2(DEPTH);
   localparam int         c_OCC_W  = c_PTR_W + 2;
   localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
   localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W + 1)'(1);
   localparam logic [c_PTR_W:0]   c_CNT_MAX = (c_PTR_W + 1)'(DEPTH);

   // Issue stage, flag-alignment stages.
   logic             r_alu_in_valid;
   logic [1:0]       r_alu_op;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic             r_s1_valid;
   logic [1:0]       r_s1_op;
   logic             r_s2_valid;
   logic [3:0]       r_s2_flags;

   // Response FIFO.
   logic [WIDTH-1:0]   r_mem_data  [DEPTH];
   logic [3:0]         r_mem_flags [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W:0]   r_count;
   logic               r_err;

   logic               w_accept;
   logic               w_nonempty;
   logic               w_full;
   logic               w_pop;
   logic               w_push_try;
   logic               w_push;
   logic               w_spurious;
   logic               w_keep_cv;
   logic [1:0]         w_inflight;
   logic [c_OCC_W-1:0] w_occupancy;

   assign w_accept   = bus.cmd_valid && bus.cmd_ready;
   assign w_nonempty = (r_count != '0);
   assign w_full     = (r_count == c_CNT_MAX);
   assign w_pop      = w_nonempty && bus.rsp_ready;
   assign w_push_try = bus.alu_out_valid && r_s2_valid;
   assign w_push     = w_push_try && !w_full;
   assign w_spurious = bus.alu_out_valid && !r_s2_valid;
   assign w_keep_cv  = (r_s1_op != c_OP_NOP);

   assign w_inflight = {1'b0, r_alu_in_valid} + {1'b0, r_s1_valid} + {1'b0, r_s2_valid};

   // Entries leaving the FIFO on this edge free their slot for a command
   // accepted on the same edge, which keeps full throughput at DEPTH = 4.
   assign w_occupancy = c_OCC_W'(r_count) + c_OCC_W'(w_inflight) - c_OCC_W'(w_pop);

   assign bus.cmd_ready = !reset && (w_occupancy < c_OCC_W'(DEPTH));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_alu_in_valid <= 1'b0;
         r_alu_op       <= c_OP_NOP;
         r_alu_a        <= '0;
         r_alu_b        <= '0;
         r_s1_valid     <= 1'b0;
         r_s1_op        <= c_OP_NOP;
         r_s2_valid     <= 1'b0;
         r_s2_flags     <= '0;
      end else begin
         r_alu_in_valid <= w_accept;
         r_alu_op       <= w_accept ? bus.cmd_op : c_OP_NOP;
         if (w_accept) begin
            r_alu_a <= bus.cmd_a;
            r_alu_b <= bus.cmd_b;
         end
         r_s1_valid <= r_alu_in_valid;
         r_s1_op    <= r_alu_op;
         r_s2_valid <= r_s1_valid;
         // Flags lead the registered result by one cycle; C/V mean nothing for nop.
         if (r_s1_valid) begin
            r_s2_flags <= {bus.alu_n, bus.alu_z,
                           w_keep_cv & bus.alu_c, w_keep_cv & bus.alu_v};
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
         if (w_spurious || (w_push_try && w_full)) begin
            r_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr]  <= bus.alu_out;
         r_mem_flags[r_wr_ptr] <= r_s2_flags;
      end
   end

   assign bus.alu_in_valid = r_alu_in_valid;
   assign bus.alu_op       = r_alu_op;
   assign bus.alu_a        = r_alu_a;
   assign bus.alu_b        = r_alu_b;

   assign bus.rsp_valid = w_nonempty;
   assign bus.rsp_data  = w_nonempty ? r_mem_data[r_rd_ptr]  : '0;
   assign bus.rsp_flags = w_nonempty ? r_mem_flags[r_rd_ptr] : 4'b0000;

   assign busy = (w_inflight != 2'd0) || w_nonempty;
   assign err  = r_err;
endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_sequencer: directed vectors against a behavioural 2-stage   |
// | ALU model.                                        Revision: 1.0    |
// +--------------------------------------------------------------------+
module tb_alu_sequencer;
   logic clk;
   logic reset;
   logic busy;
   logic err;
   logic inject;

   int n_vec = 0;
   int n_bad = 0;

   alu_sequencer_if #(.WIDTH(32)) bus ();

   alu_sequencer #(.WIDTH(32), .DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .busy  (busy),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU model: inputs registered at E1, flags combinational from that stage,
   // result registered at E2.
   logic        m_v;
   logic [1:0]  m_op;
   logic [31:0] m_a;
   logic [31:0] m_b;
   logic [31:0] m_res;
   logic [31:0] m_out;
   logic        m_out_v;
   logic [32:0] m_sum;
   logic        m_n, m_z, m_c, m_vf;

   always_comb begin
      m_sum = '0;
      m_res = '0;
      m_n   = 1'b0;
      m_z   = 1'b1;
      m_c   = 1'b1;
      m_vf  = 1'b1;
      if (m_op == 2'd0) begin
         m_sum = {1'b0, m_a} + {1'b0, m_b};
         m_res = m_sum[31:0];
         m_c   = m_sum[32];
         m_vf  = (m_a[31] == m_b[31]) && (m_res[31] != m_a[31]);
         m_n   = m_res[31];
         m_z   = (m_res == 32'd0);
      end else if (m_op == 2'd1) begin
         m_sum = {1'b0, m_a} + {1'b0, ~m_b} + 33'd1;
         m_res = m_sum[31:0];
         m_c   = m_sum[32];
         m_vf  = (m_a[31] != m_b[31]) && (m_res[31] != m_a[31]);
         m_n   = m_res[31];
         m_z   = (m_res == 32'd0);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_v     <= 1'b0;
         m_op    <= 2'd2;
         m_a     <= '0;
         m_b     <= '0;
         m_out   <= '0;
         m_out_v <= 1'b0;
      end else begin
         m_v     <= bus.alu_in_valid;
         m_op    <= bus.alu_op;
         m_a     <= bus.alu_a;
         m_b     <= bus.alu_b;
         m_out   <= m_res;
         m_out_v <= m_v;
      end
   end

   assign bus.alu_n         = m_n;
   assign bus.alu_z         = m_z;
   assign bus.alu_c         = m_c;
   assign bus.alu_v         = m_vf;
   assign bus.alu_out       = m_out;
   assign bus.alu_out_valid = m_out_v | inject;

   typedef struct packed {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] data;
      logic [3:0]  flags;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = v.op;
      bus.cmd_a     = v.a;
      bus.cmd_b     = v.b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int idx;
   int got;
   int first_rsp;
   int last_rsp;
   int acc;
   int stale;
   logic [31:0] bp_exp [4];

   initial begin
      // {op, a, b, expected data, expected {N,Z,C,V}}
      vecs[0] = '{2'd0, 32'd5,          32'd3,  32'd8,          4'b0000};
      vecs[1] = '{2'd1, 32'd3,          32'd3,  32'd0,          4'b0110};
      vecs[2] = '{2'd1, 32'h8000_0000,  32'd1,  32'h7FFF_FFFF,  4'b0011};
      vecs[3] = '{2'd0, 32'hFFFF_FFFF,  32'd1,  32'd0,          4'b0110};
      vecs[4] = '{2'd2, 32'h1234,       32'h5678, 32'd0,        4'b0100};
      vecs[5] = '{2'd1, 32'd2,          32'd5,  32'hFFFF_FFFD,  4'b1000};
      vecs[6] = '{2'd0, 32'h7FFF_FFFF,  32'd1,  32'h8000_0000,  4'b1001};

      reset         = 1'b1;
      inject        = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'd2;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      check("rst_cmd_ready",    32'(bus.cmd_ready),    32'd0);
      check("rst_alu_in_valid", 32'(bus.alu_in_valid), 32'd0);
      check("rst_alu_op",       32'(bus.alu_op),       32'd2);
      check("rst_alu_a",        bus.alu_a,             32'd0);
      check("rst_alu_b",        bus.alu_b,             32'd0);
      check("rst_rsp_valid",    32'(bus.rsp_valid),    32'd0);
      check("rst_rsp_data",     bus.rsp_data,          32'd0);
      check("rst_rsp_flags",    32'(bus.rsp_flags),    32'd0);
      check("rst_busy",         32'(busy),             32'd0);
      check("rst_err",          32'(err),              32'd0);

      reset = 1'b0;
      #1;
      check("cmd_ready_after_rst", 32'(bus.cmd_ready), 32'd1);
      tick();

      // Single commands: issue stage, 3-cycle latency, flags pairing.
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         drive(vecs[i]);
         check("single_ready", 32'(bus.cmd_ready), 32'd1);
         tick();
         bus.cmd_valid = 1'b0;
         bus.cmd_op    = 2'd2;
         check("issue_valid", 32'(bus.alu_in_valid), 32'd1);
         check("issue_op",    32'(bus.alu_op),       32'(vecs[i].op));
         check("issue_a",     bus.alu_a,             vecs[i].a);
         check("issue_b",     bus.alu_b,             vecs[i].b);
         tick();
         check("idle_valid",  32'(bus.alu_in_valid), 32'd0);
         check("idle_op",     32'(bus.alu_op),       32'd2);
         check("lat_e1",      32'(bus.rsp_valid),    32'd0);
         tick();
         check("lat_e2",      32'(bus.rsp_valid),    32'd0);
         tick();
         check("lat_e3",      32'(bus.rsp_valid),    32'd1);
         check("single_data", bus.rsp_data,          vecs[i].data);
         check("single_flags", 32'(bus.rsp_flags),   32'(vecs[i].flags));
         tick();
         check("single_drained", 32'(bus.rsp_valid), 32'd0);
         check("single_busy",    32'(busy),          32'd0);
      end

      // Back-to-back stream of 8 mixed commands.
      idx       = 0;
      got       = 0;
      first_rsp = -1;
      last_rsp  = -1;
      for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
         if (bus.rsp_valid) begin
            check("b2b_data",  bus.rsp_data,        vecs[got % 7].data);
            check("b2b_flags", 32'(bus.rsp_flags),  32'(vecs[got % 7].flags));
            if (first_rsp < 0) first_rsp = cyc;
            last_rsp = cyc;
            got++;
         end
         if (idx < 8) drive(vecs[idx % 7]);
         else bus.cmd_valid = 1'b0;
         #1;
         if (idx < 8) begin
            check("b2b_ready", 32'(bus.cmd_ready), 32'd1);
            if (bus.cmd_ready) idx++;
         end
         @(posedge clk);
         #1;
      end
      bus.cmd_valid = 1'b0;
      check("b2b_count", 32'(got),                  32'd8);
      check("b2b_first", 32'(first_rsp),            32'd4);
      check("b2b_span",  32'(last_rsp - first_rsp), 32'd7);

      // Backpressure: exactly DEPTH commands fit, then drain in order.
      bus.rsp_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 4; i++) bp_exp[i] = 32'h100 * (i + 1) + i;
      for (int cyc = 0; cyc < 10; cyc++) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_op    = 2'd0;
         bus.cmd_a     = 32'h100 * (acc + 1);
         bus.cmd_b     = 32'(acc);
         #1;
         if (bus.cmd_ready) acc++;
         @(posedge clk);
         #1;
      end
      bus.cmd_valid = 1'b0;
      check("bp_accepted",  32'(acc),            32'd4);
      check("bp_ready_low", 32'(bus.cmd_ready),  32'd0);
      check("bp_head",      bus.rsp_data,        bp_exp[0]);
      tick();
      check("bp_head_hold", bus.rsp_data,        bp_exp[0]);
      check("bp_busy",      32'(busy),           32'd1);
      bus.rsp_ready = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
         if (bus.rsp_valid) begin
            check("drain_data", bus.rsp_data, bp_exp[got]);
            got++;
         end
         tick();
      end
      check("drain_count", 32'(got),           32'd4);
      check("drain_empty", 32'(bus.rsp_valid), 32'd0);
      check("drain_err",   32'(err),           32'd0);

      // Reset with one buffered response and two commands in flight.
      bus.rsp_ready = 1'b0;
      drive(vecs[0]);
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      drive(vecs[1]);
      tick();
      drive(vecs[2]);
      tick();
      bus.cmd_valid = 1'b0;
      check("pre_rst_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("pre_rst_busy",      32'(busy),          32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("mid_rst_busy",      32'(busy),          32'd0);
      check("mid_rst_ready",     32'(bus.cmd_ready), 32'd0);
      tick();
      reset = 1'b0;
      bus.rsp_ready = 1'b1;
      stale = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         if (bus.rsp_valid || busy) stale++;
         tick();
      end
      check("no_stale", 32'(stale), 32'd0);
      check("post_rst_err", 32'(err), 32'd0);

      // Spurious result: sticky error, nothing pushed, cleared by reset only.
      inject = 1'b1;
      tick();
      inject = 1'b0;
      check("spurious_err",    32'(err),           32'd1);
      check("spurious_no_rsp", 32'(bus.rsp_valid), 32'd0);
      repeat (3) tick();
      check("err_sticky", 32'(err), 32'd1);
      reset = 1'b1;
      #1;
      check("err_cleared", 32'(err), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
